// File: rtl/dram_bank_ctrl.sv
// Single-bank DRAM-style controller: open-row tracking, T_RCD activate delay,
// one-cycle access and periodic refresh in front of an inferred word memory.
module dram_bank_ctrl #(
    parameter int DATA_W           = 8,
    parameter int ADDR_W           = 4,
    parameter int COL_W            = 2,
    parameter int T_RCD            = 2,
    parameter int REFRESH_INTERVAL = 32,
    parameter int REFRESH_CYCLES   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    output logic              ready,
    output logic [DATA_W-1:0] out,
    output logic              valid,
    output logic              refreshing
);
    localparam int ROW_W  = ADDR_W - COL_W;
    localparam int PH_MAX = (T_RCD > REFRESH_CYCLES) ? T_RCD : REFRESH_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int RI_W   = $clog2(REFRESH_INTERVAL);

    typedef enum logic [1:0] {IDLE, ACTIVATE, ACCESS, REFRESH} state_t;

    state_t              state_reg, state_next;
    logic [PH_W-1:0]     phase_reg, phase_next;
    logic                row_open_reg, row_open_next;
    logic [ROW_W-1:0]    open_row_reg, open_row_next;
    logic                wr_reg, wr_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]   data_reg, data_next;
    logic [DATA_W-1:0]   out_reg;
    logic                valid_reg, valid_next;
    logic [RI_W-1:0]     ref_cnt_reg, ref_cnt_next;
    logic                ref_pending_reg, ref_pending_next;
    logic                ref_wrap;

    logic [DATA_W-1:0]   mem [2**ADDR_W];

    assign ready      = (state_reg == IDLE) && !ref_pending_reg;
    assign out        = out_reg;
    assign valid      = valid_reg;
    assign refreshing = (state_reg == REFRESH);
    assign ref_wrap   = (ref_cnt_reg == RI_W'(REFRESH_INTERVAL - 1));

    always_comb begin
        state_next       = state_reg;
        phase_next       = phase_reg;
        row_open_next    = row_open_reg;
        open_row_next    = open_row_reg;
        wr_next          = wr_reg;
        addr_next        = addr_reg;
        data_next        = data_reg;
        valid_next       = 1'b0;
        ref_cnt_next     = ref_wrap ? '0 : ref_cnt_reg + 1'b1;
        ref_pending_next = ref_pending_reg;

        case (state_reg)
            IDLE: begin
                if (ref_pending_reg) begin
                    state_next = REFRESH;
                    phase_next = '0;
                end else if (req) begin
                    wr_next    = wr;
                    addr_next  = addr;
                    data_next  = data;
                    phase_next = '0;
                    if (row_open_reg && open_row_reg == addr[ADDR_W-1:COL_W])
                        state_next = ACCESS;
                    else
                        state_next = ACTIVATE;
                end
            end
            ACTIVATE: begin
                if (phase_reg == PH_W'(T_RCD - 1)) begin
                    state_next    = ACCESS;
                    row_open_next = 1'b1;
                    open_row_next = addr_reg[ADDR_W-1:COL_W];
                end else begin
                    phase_next = phase_reg + 1'b1;
                end
            end
            ACCESS: begin
                state_next = IDLE;
                valid_next = !wr_reg;
            end
            REFRESH: begin
                if (phase_reg == PH_W'(REFRESH_CYCLES - 1)) begin
                    state_next       = IDLE;
                    row_open_next    = 1'b0;
                    ref_pending_next = 1'b0;
                end else begin
                    phase_next = phase_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // A new interval expiring takes priority over the clear on refresh exit.
        if (ref_wrap)
            ref_pending_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg       <= IDLE;
            phase_reg       <= '0;
            row_open_reg    <= 1'b0;
            open_row_reg    <= '0;
            wr_reg          <= 1'b0;
            addr_reg        <= '0;
            data_reg        <= '0;
            out_reg         <= '0;
            valid_reg       <= 1'b0;
            ref_cnt_reg     <= '0;
            ref_pending_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            phase_reg       <= phase_next;
            row_open_reg    <= row_open_next;
            open_row_reg    <= open_row_next;
            wr_reg          <= wr_next;
            addr_reg        <= addr_next;
            data_reg        <= data_next;
            valid_reg       <= valid_next;
            ref_cnt_reg     <= ref_cnt_next;
            ref_pending_reg <= ref_pending_next;
            if (state_reg == ACCESS && !wr_reg)
                out_reg <= mem[addr_reg];
        end
    end

    // Storage is never cleared; reset only blocks a write landing on its edge.
    always_ff @(posedge clk) begin
        if (rst && state_reg == ACCESS && wr_reg)
            mem[addr_reg] <= data_reg;
    end
endmodule

// File: tb/tb_dram_bank_ctrl.sv
// Scoreboard bench for dram_bank_ctrl: stimulus pushes expected read data and
// latency, an independent monitor pops and compares on every valid pulse.
module tb_dram_bank_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req = 1'b0;
    logic       wr = 1'b0;
    logic [3:0] addr = '0;
    logic [7:0] data = '0;
    logic       ready, valid, refreshing;
    logic [7:0] dout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] d;
        int         lat;
        int         acc;
        logic [3:0] a;
    } exp_t;
    exp_t q[$];

    dram_bank_ctrl #(
        .DATA_W(8), .ADDR_W(4), .COL_W(2), .T_RCD(2),
        .REFRESH_INTERVAL(32), .REFRESH_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .data(data),
        .ready(ready), .out(dout), .valid(valid), .refreshing(refreshing)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: every valid pulse must match the oldest outstanding read.
    always @(negedge clk) begin
        if (rst && valid) begin
            if (q.size() == 0) begin
                check("unexpected_valid", 32'(valid), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("rd_data", 32'(dout), 32'(e.d));
                check("rd_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                $display("read  addr=%h data=%h latency=%0d", e.a, dout, cyc - e.acc + 1);
            end
        end
    end

    // Called at a negedge; returns at the negedge right after the acceptance edge.
    task automatic issue(input logic w, input logic [3:0] a, input logic [7:0] d, input int lat_exp);
        int n;
        exp_t e;
        n = 0;
        while (!ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            check("wait_ready", 32'(ready), 32'd1);
            return;
        end
        req = 1'b1; wr = w; addr = a; data = d;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        if (!w) begin
            e.d = d; e.lat = lat_exp; e.acc = cyc; e.a = a;
            q.push_back(e);
        end
        $display("issue %s addr=%h data=%h", w ? "write" : "read ", a, d);
        check("busy_after_accept", 32'(ready), 32'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || !ready) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("drain_outstanding", 32'(q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out", 32'(dout), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_refreshing", 32'(refreshing), 32'd0);
        rst = 1'b1;
    endtask

    initial begin
        int n;
        @(negedge clk);
        do_reset();

        // Writes miss then hit; row changes force misses.
        issue(1'b1, 4'h5, 8'hFF, 0);
        issue(1'b0, 4'h5, 8'hFF, 2);
        issue(1'b1, 4'hC, 8'h5A, 0);
        issue(1'b0, 4'h5, 8'hFF, 4);
        issue(1'b0, 4'hC, 8'h5A, 4);
        drain();

        // Refresh timing from reset release, with an ignored write held over REFRESH.
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            @(negedge clk);
            check($sformatf("ready_e%0d", e), 32'(ready), (e < 32 || e >= 37) ? 32'd1 : 32'd0);
            check($sformatf("refreshing_e%0d", e), 32'(refreshing),
                  (e >= 33 && e <= 36) ? 32'd1 : 32'd0);
            if (e == 33) begin
                req = 1'b1; wr = 1'b1; addr = 4'h5; data = 8'hAA;
            end
            if (e == 37) req = 1'b0;
        end
        issue(1'b0, 4'hC, 8'h5A, 4);
        issue(1'b0, 4'h5, 8'hFF, 4);
        drain();

        // Row 1 is open; after the next refresh the same row must miss again.
        n = 0;
        while (!refreshing && n < 80) begin @(negedge clk); n++; end
        while (refreshing && n < 80) begin @(negedge clk); n++; end
        check("refresh_seen", 32'(n < 80), 32'd1);
        issue(1'b0, 4'h5, 8'hFF, 4);
        drain();

        // Reset during ACTIVATE, then reset on the ACCESS edge of a hit write.
        do_reset();
        issue(1'b1, 4'h2, 8'h11, 0);
        issue(1'b0, 4'hC, 8'h5A, 4);
        issue(1'b1, 4'h2, 8'h3C, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("midop_rst_ready", 32'(ready), 32'd1);
        rst = 1'b1;
        issue(1'b0, 4'h2, 8'h11, 4);
        drain();
        issue(1'b1, 4'h2, 8'h3C, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        issue(1'b0, 4'h2, 8'h11, 4);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
